// File: rtl/score_argmax.sv
// score_argmax: streaming argmax over NUM_CLASSES unsigned class scores per image.
// Scores arrive one per accept beat (class 0 first). After the last class, the winning index
// and score are held on digit/digit_score with digit_valid until the consumer takes them.
// Ties keep the lower index.
// Optional feature: define ARGMAX_MARGIN_EN to add margin (best minus second best) and
// low_conf (margin < MARGIN_THRESH) outputs.
module score_argmax #(
  parameter int NUM_CLASSES   = 10,
  parameter int MARGIN_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_valid,
  input  logic [7:0] score,
  output logic       score_ready,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic [3:0] digit,
  output logic [7:0] digit_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [7:0] margin,
  output logic       low_conf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  // The index is 4 bits wide and the margin threshold is compared as an 8-bit value.
  if (NUM_CLASSES < 2 || NUM_CLASSES > 16 || MARGIN_THRESH < 0 || MARGIN_THRESH > 255)
  begin : g_param_err
    $error("score_argmax: NUM_CLASSES must be 2..16 and MARGIN_THRESH 0..255");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] best_q, best_d;
  logic [3:0] best_idx_q, best_idx_d;
  logic [3:0] digit_q;
  logic [7:0] digit_score_q;

  logic accept;
  logic last_beat;

  assign score_ready = (state_q != DONE);
  assign digit_valid = (state_q == DONE);
  assign accept      = score_valid & score_ready;
  assign last_beat   = accept & (cnt_q == LAST_IDX);
  assign digit       = digit_q;
  assign digit_score = digit_score_q;

  // Running best: class 0 loads unconditionally, later classes win only on strictly greater.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (accept) begin
      if (cnt_q == 4'd0) begin
        best_d     = score;
        best_idx_d = 4'd0;
      end else if (score > best_q) begin
        best_d     = score;
        best_idx_d = cnt_q;
      end
    end
  end

  // Next state and class counter; the counter wraps to 0 as the result is latched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (last_beat) begin
      cnt_d = 4'd0;
    end else if (accept) begin
      cnt_d = cnt_q + 4'd1;
    end
    case (state_q)
      IDLE:    if (last_beat) state_d = DONE; else if (accept) state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DONE;
      DONE:    if (digit_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and running best registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      best_q     <= 8'd0;
      best_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  // Result registers capture the final best on the last beat and hold until the next image ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q       <= 4'd0;
      digit_score_q <= 8'd0;
    end else if (last_beat) begin
      digit_q       <= best_idx_d;
      digit_score_q <= best_d;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  localparam logic [7:0] THRESH = 8'(MARGIN_THRESH);

  logic [7:0] second_q, second_d;
  logic [7:0] margin_q;
  logic       low_conf_q;
  logic [7:0] margin_d;

  assign margin   = margin_q;
  assign low_conf = low_conf_q;
  assign margin_d = best_d - second_d;

  // Second best: a displaced best becomes second; a tie with best lands here too (margin 0).
  always_comb begin
    second_d = second_q;
    if (accept) begin
      if (cnt_q == 4'd0) begin
        second_d = 8'd0;
      end else if (score > best_q) begin
        second_d = best_q;
      end else if (score > second_q) begin
        second_d = score;
      end
    end
  end

  // Second-best tracker plus margin outputs latched alongside the digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      second_q   <= 8'd0;
      margin_q   <= 8'd0;
      low_conf_q <= 1'b0;
    end else begin
      second_q <= second_d;
      if (last_beat) begin
        margin_q   <= margin_d;
        low_conf_q <= (margin_d < THRESH);
      end
    end
  end
`else
  // Default build: result carries only the winning index and score.
`endif

endmodule
